// File: rtl/cmos_pad_ctrl.sv
// ---------------------------------------------------------------------------
// cmos_pad_ctrl
//
// Direction and transfer sequencer for one side's bidirectional CMOS pad bank.
// A write requester drives a pattern onto the pads. A read requester samples
// the pads. Output-enable turnaround gaps keep the pads from being driven into
// an external driver.
//
// Handshake: a requester raises *_REQ and holds it until the matching *_ACK
// pulse, which lasts one cycle. If a request is still high in IDLE after its
// ACK, it is taken as a new request. WR_DATA is sampled only at the write grant
// edge. RD_DATA is valid in the RD_ACK cycle and holds until the next capture.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   ENABLE          0 releases the pads and blocks new grants
//   WR_REQ/WR_DATA  write request and pattern; WR_ACK one-cycle accept pulse
//   RD_REQ          read request; RD_ACK one-cycle pulse with RD_DATA valid
//   CMOS_OUT/OEN    pad output data and active-low output enable
//   CMOS_IN         pad input data from the padring
//   BUSY            high whenever the sequencer is not IDLE
//   DBG_STATE       current FSM state (debug observation)
// ---------------------------------------------------------------------------
module cmos_pad_ctrl #(
    parameter int WIDTH    = 40,
    parameter int DRV_CYC  = 4,
    parameter int TURN_CYC = 2,
    parameter int RD_WAIT  = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             WR_REQ,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             WR_ACK,
    input  logic             RD_REQ,
    output logic             RD_ACK,
    output logic [WIDTH-1:0] RD_DATA,
    output logic [WIDTH-1:0] CMOS_OUT,
    output logic             CMOS_OEN,
    input  logic [WIDTH-1:0] CMOS_IN,
    output logic             BUSY,
    output logic [2:0]       DBG_STATE
);

    localparam int MAX_CYC = (DRV_CYC > TURN_CYC) ?
                             ((DRV_CYC > RD_WAIT) ? DRV_CYC : RD_WAIT) :
                             ((TURN_CYC > RD_WAIT) ? TURN_CYC : RD_WAIT);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_DRIVE = 3'd2,
        S_TURN  = 3'd3,
        S_RWAIT = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prio_wr_q;   // 0 = read side wins the next tie

    logic grant_wr_d;
    logic grant_rd_d;
    logic cnt_last;
    logic both_req;

    assign DBG_STATE = state_q;
    assign cnt_last  = (cnt_q == CNT_W'(1));
    assign both_req  = WR_REQ && RD_REQ;

    // Arbitration is evaluated only in IDLE with ENABLE high. The pointer
    // decides only ties.
    always_comb begin
        grant_wr_d = 1'b0;
        grant_rd_d = 1'b0;
        if (state_q == S_IDLE && ENABLE) begin
            if (both_req) begin
                grant_wr_d = prio_wr_q;
                grant_rd_d = !prio_wr_q;
            end else begin
                grant_wr_d = WR_REQ;
                grant_rd_d = RD_REQ;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prio_wr_q <= 1'b0;
            CMOS_OEN  <= 1'b1;
            CMOS_OUT  <= '0;
            RD_DATA   <= '0;
            WR_ACK    <= 1'b0;
            RD_ACK    <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            WR_ACK <= 1'b0;
            RD_ACK <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ENABLE && both_req) begin
                        prio_wr_q <= !prio_wr_q;
                    end
                    if (grant_wr_d) begin
                        CMOS_OUT <= WR_DATA;
                        WR_ACK   <= 1'b1;
                        BUSY     <= 1'b1;
                        state_q  <= S_SETUP;
                        cnt_q    <= CNT_W'(1);
                    end else if (grant_rd_d) begin
                        BUSY     <= 1'b1;
                        state_q  <= S_RWAIT;
                        cnt_q    <= CNT_W'(RD_WAIT);
                    end
                end
                // Data is already on CMOS_OUT. It settles one cycle before
                // the enable.
                S_SETUP: begin
                    if (!ENABLE) begin
                        state_q <= S_TURN;
                        cnt_q   <= CNT_W'(TURN_CYC);
                    end else if (cnt_last) begin
                        CMOS_OEN <= 1'b0;
                        state_q  <= S_DRIVE;
                        cnt_q    <= CNT_W'(DRV_CYC);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // When ENABLE drops, the remaining drive cycles are cut short,
                // but the full turnaround still runs.
                S_DRIVE: begin
                    if (!ENABLE || cnt_last) begin
                        CMOS_OEN <= 1'b1;
                        state_q  <= S_TURN;
                        cnt_q    <= CNT_W'(TURN_CYC);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_TURN: begin
                    if (cnt_last) begin
                        BUSY    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // Reads never drive the pads, so ENABLE has no effect here.
                S_RWAIT: begin
                    if (cnt_last) begin
                        RD_DATA <= CMOS_IN;
                        RD_ACK  <= 1'b1;
                        BUSY    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    CMOS_OEN <= 1'b1;
                    BUSY     <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_pad_ctrl.sv
module tb_cmos_pad_ctrl;

    localparam int W = 40;
    localparam logic [W-1:0] PAT_A = 40'hA5_5A5A_5A5A;
    localparam logic [W-1:0] PAT_C = 40'h12_3456_789A;
    localparam logic [W-1:0] ONES  = 40'hFF_FFFF_FFFF;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         ENABLE;
    logic         WR_REQ;
    logic [W-1:0] WR_DATA;
    logic         WR_ACK;
    logic         RD_REQ;
    logic         RD_ACK;
    logic [W-1:0] RD_DATA;
    logic [W-1:0] CMOS_OUT;
    logic         CMOS_OEN;
    logic [W-1:0] CMOS_IN;
    logic         BUSY;
    logic [2:0]   DBG_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    // Grant-order scoreboard: 0 = read, 1 = write.
    logic [0:0] exp_q[$];

    typedef struct {
        logic         en;
        logic         wr;
        logic         rd;
        logic [W-1:0] wdata;
        logic [W-1:0] cin;
        logic         exp_oen;
        logic [W-1:0] exp_out;
        logic         exp_wack;
        logic         exp_rack;
        logic         exp_busy;
        logic [W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    cmos_pad_ctrl dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ENABLE    (ENABLE),
        .WR_REQ    (WR_REQ),
        .WR_DATA   (WR_DATA),
        .WR_ACK    (WR_ACK),
        .RD_REQ    (RD_REQ),
        .RD_ACK    (RD_ACK),
        .RD_DATA   (RD_DATA),
        .CMOS_OUT  (CMOS_OUT),
        .CMOS_OEN  (CMOS_OEN),
        .CMOS_IN   (CMOS_IN),
        .BUSY      (BUSY),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / check tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && BUSY !== 1'b0; i++) step();
        chk("idle_wait", {63'd0, BUSY}, 64'd0);
    endtask

    task automatic apply_rows(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            ENABLE  = vecs[i].en;
            WR_REQ  = vecs[i].wr;
            RD_REQ  = vecs[i].rd;
            WR_DATA = vecs[i].wdata;
            CMOS_IN = vecs[i].cin;
            step();
            chk($sformatf("%s_row%0d_oen", tag, i), {63'd0, CMOS_OEN}, {63'd0, vecs[i].exp_oen});
            chk($sformatf("%s_row%0d_out", tag, i), {24'd0, CMOS_OUT}, {24'd0, vecs[i].exp_out});
            chk($sformatf("%s_row%0d_wack", tag, i), {63'd0, WR_ACK}, {63'd0, vecs[i].exp_wack});
            chk($sformatf("%s_row%0d_rack", tag, i), {63'd0, RD_ACK}, {63'd0, vecs[i].exp_rack});
            chk($sformatf("%s_row%0d_busy", tag, i), {63'd0, BUSY}, {63'd0, vecs[i].exp_busy});
            chk($sformatf("%s_row%0d_rdata", tag, i), {24'd0, RD_DATA}, {24'd0, vecs[i].exp_rdata});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acks;
        int last_c;
        logic [0:0] last_kind;
        logic [0:0] got;

        // Each row lists the inputs applied before an edge and the outputs
        // expected just after that edge.
        //             en    wr    rd    wdata  cin    oen   out    wack  rack  busy  rdata
        // Write: grant, SETUP, 4x DRIVE, 2x TURN, IDLE
        vecs[0]  = '{1'b1, 1'b1, 1'b0, PAT_A, '0,    1'b1, PAT_A, 1'b1, 1'b0, 1'b1, '0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, ONES,  '0,    1'b0, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, ONES,  '0,    1'b0, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, ONES,  '0,    1'b0, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, ONES,  '0,    1'b0, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, ONES,  '0,    1'b1, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, ONES,  '0,    1'b1, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, ONES,  '0,    1'b1, PAT_A, 1'b0, 1'b0, 1'b0, '0};
        // Read: grant, RWAIT, capture+ack, then CMOS_IN changes
        vecs[8]  = '{1'b1, 1'b0, 1'b1, '0,    PAT_C, 1'b1, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, '0,    PAT_C, 1'b1, PAT_A, 1'b0, 1'b0, 1'b1, '0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, '0,    PAT_C, 1'b1, PAT_A, 1'b0, 1'b1, 1'b0, PAT_C};
        vecs[11] = '{1'b1, 1'b0, 1'b0, '0,    ONES,  1'b1, PAT_A, 1'b0, 1'b0, 1'b0, PAT_C};
        vecs[12] = '{1'b1, 1'b0, 1'b0, '0,    '0,    1'b1, PAT_A, 1'b0, 1'b0, 1'b0, PAT_C};

        // Reset and idle
        RST_N = 1'b0; ENABLE = 1'b1; WR_REQ = 1'b0; RD_REQ = 1'b0;
        WR_DATA = '0; CMOS_IN = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("rst_idle%0d_oen", i), {63'd0, CMOS_OEN}, 64'd1);
            chk($sformatf("rst_idle%0d_busy_acks", i), {61'd0, BUSY, WR_ACK, RD_ACK}, 64'd0);
        end
        chk("rst_out", {24'd0, CMOS_OUT}, 64'd0);
        chk("rst_rdata", {24'd0, RD_DATA}, 64'd0);

        // Single write, then single read
        apply_rows(0, 12, "wr_rd");

        // Both requests held: round-robin starting with read
        wait_idle();
        WR_DATA = 40'h0F_0F0F_0F0F;
        CMOS_IN = 40'h33_CCCC_3333;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        WR_REQ = 1'b1; RD_REQ = 1'b1;
        acks = 0; last_c = 0; last_kind = 1'b0;
        for (int c = 0; c < 80 && acks < 4; c++) begin
            step();
            chk("oen_only_in_drive", {63'd0, (!CMOS_OEN && DBG_STATE != 3'd2)}, 64'd0);
            if (RD_ACK || WR_ACK) begin
                got = WR_ACK ? 1'b1 : 1'b0;
                if (exp_q.size() == 0) begin
                    chk("rr_unexpected_ack", 64'd1, 64'd0);
                end else begin
                    chk($sformatf("rr_grant%0d", acks), {63'd0, got}, {63'd0, exp_q.pop_front()});
                end
                if (acks > 0 && last_kind == 1'b1 && got == 1'b0)
                    chk("rr_wr_to_rd_gap", 64'(c - last_c), 64'd10);
                if (acks > 0 && last_kind == 1'b0 && got == 1'b1)
                    chk("rr_rd_to_wr_gap", 64'(c - last_c), 64'd1);
                if (got == 1'b0)
                    chk("rr_rdata", {24'd0, RD_DATA}, {24'd0, 40'h33_CCCC_3333});
                last_c = c; last_kind = got;
                acks++;
            end
        end
        WR_REQ = 1'b0; RD_REQ = 1'b0;
        chk("rr_ack_count", 64'(acks), 64'd4);
        chk("rr_queue_empty", 64'(exp_q.size()), 64'd0);

        // ENABLE dropped in the second DRIVE cycle
        wait_idle();
        WR_DATA = 40'h5A_A5A5_A5A5; WR_REQ = 1'b1;
        step();
        chk("en_grant_ack", {63'd0, WR_ACK}, 64'd1);
        WR_REQ = 1'b0;
        step();
        chk("en_drive1_oen", {63'd0, CMOS_OEN}, 64'd0);
        step();
        chk("en_drive2_oen", {63'd0, CMOS_OEN}, 64'd0);
        ENABLE = 1'b0;
        step();
        chk("en_cut_oen", {63'd0, CMOS_OEN}, 64'd1);
        chk("en_cut_busy", {63'd0, BUSY}, 64'd1);
        step();
        chk("en_turn2_busy", {63'd0, BUSY}, 64'd1);
        step();
        chk("en_idle_busy", {63'd0, BUSY}, 64'd0);
        chk("en_out_kept", {24'd0, CMOS_OUT}, {24'd0, 40'h5A_A5A5_A5A5});
        WR_DATA = 40'h01_0203_0405; WR_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("en_blocked%0d", i), {61'd0, WR_ACK, RD_ACK, BUSY}, 64'd0);
        end
        ENABLE = 1'b1;
        step();
        chk("en_resume_ack", {63'd0, WR_ACK}, 64'd1);
        chk("en_resume_out", {24'd0, CMOS_OUT}, {24'd0, 40'h01_0203_0405});
        WR_REQ = 1'b0;

        // Asynchronous reset mid-DRIVE
        wait_idle();
        WR_DATA = 40'hC3_3C3C_3C3C; WR_REQ = 1'b1;
        step();
        WR_REQ = 1'b0;
        step();
        step();
        chk("arst_pre_oen", {63'd0, CMOS_OEN}, 64'd0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_oen", {63'd0, CMOS_OEN}, 64'd1);
        chk("arst_out", {24'd0, CMOS_OUT}, 64'd0);
        chk("arst_busy", {63'd0, BUSY}, 64'd0);
        chk("arst_rdata", {24'd0, RD_DATA}, 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        apply_rows(0, 7, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmos_pad_ctrl.md
Name: cmos_pad_ctrl

Overview:
- Direction and transfer sequencer for one side's 40-bit bidirectional CMOS pad bank. One instance per side (top, bottom).
- Shares the pad bus between a write requester, which drives a pattern out, and a read requester, which samples the pads.
- Guarantees output-enable turnaround gaps so the pads are never driven into an external driver.
- Drives the padring's per-side CMOS_OUT/CMOS_OEN and consumes its CMOS_IN.

Parameters:
- WIDTH, 40, pad bus width.
- DRV_CYC, 4, cycles the pads are actively driven per write (>=1).
- TURN_CYC, 2, released cycles after each drive before any new grant (>=1).
- RD_WAIT, 2, cycles between read grant and CMOS_IN capture; covers pad/input settling (>=1).

Ports:
- CLK  in  1  block clock.
- RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  0 forces pads released and blocks new grants.
- WR_REQ  in  1  write request; held until WR_ACK.
- WR_DATA  in  WIDTH  pattern to drive; sampled at grant.
- WR_ACK  out  1  one-cycle pulse; write accepted.
- RD_REQ  in  1  read request; held until RD_ACK.
- RD_ACK  out  1  one-cycle pulse; RD_DATA valid this cycle.
- RD_DATA  out  WIDTH  captured pad value; holds until the next capture.
- CMOS_OUT  out  WIDTH  pad output data.
- CMOS_OEN  out  1  pad output enable, active low; 1 = high-Z.
- CMOS_IN  in  WIDTH  pad input data from the padring.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock, reset and outputs:
  - One clock: CLK.
  - Reset: RST_N, asynchronous assert, active low; released synchronously to CLK by the system.
  - All outputs are registered.
- Reset values: CMOS_OEN=1, CMOS_OUT=0, RD_DATA=0, WR_ACK=0, RD_ACK=0, BUSY=0, state=IDLE, priority pointer=READ.
- States: IDLE, SETUP, DRIVE, TURN, RWAIT.
- IDLE (OEN=1):
  - If ENABLE=1, arbitrate WR_REQ/RD_REQ.
  - Single request: grant it.
  - Both requests: grant the side named by the priority pointer, then point it at the other side (round-robin). The pointer updates only on simultaneous requests.
- Write grant at edge E:
  - CMOS_OUT<=WR_DATA, WR_ACK=1 for the following cycle, go to SETUP.
  - SETUP: 1 cycle, OEN=1; data settles before enable.
  - DRIVE: OEN=0 for exactly DRV_CYC cycles; CMOS_OUT constant.
  - TURN: OEN=1 for exactly TURN_CYC cycles, then IDLE.
  - CMOS_OUT keeps its last value after release.
  - Write grant to next grant: minimum 2+DRV_CYC+TURN_CYC cycles.
- Read grant at edge E:
  - Go to RWAIT for RD_WAIT cycles; OEN stays 1.
  - On the edge ending RWAIT: RD_DATA<=CMOS_IN, RD_ACK=1 for the following cycle, return to IDLE.
  - Because reads start only from IDLE, the pads have always been released for >=TURN_CYC cycles since the last drive.
- Request protocol:
  - A request still high in IDLE after its ACK is treated as a new request. Requesters deassert in the ACK cycle for single transfers.
  - WR_DATA is ignored except at the grant edge.
- ENABLE=0:
  - In SETUP or DRIVE: next edge sets OEN=1 and enters TURN, which completes normally. The remaining drive cycles are lost, and WR_ACK has already been given.
  - In RWAIT: the read completes normally (no drive hazard).
  - In IDLE: no grants; requests stay pending.
- Counters: a single down-counter, sized for max(DRV_CYC, TURN_CYC, RD_WAIT), reloaded on each state entry. The state advances when the counter reaches 1.
- Reset mid-operation: immediate async return to reset values. OEN=1 takes effect without waiting for a clock edge.
- CMOS_OEN never goes 0 outside DRIVE. After a DRIVE→IDLE release, CMOS_OEN never goes 0 within TURN_CYC cycles.

Test Plan:
1. Reset, then hold RST_N=1 for 10 cycles with no requests -> OEN=1, CMOS_OUT=0, RD_DATA=0, BUSY=0, no ACKs.
2. WR_REQ with WR_DATA=40'hA5_5A5A_5A5A (defaults) -> WR_ACK 1 cycle after grant; CMOS_OUT=WR_DATA; OEN=0 for exactly 4 cycles starting 2 cycles after grant; then 2 released cycles; BUSY low on cycle 8.
3. CMOS_IN=40'h12_3456_789A and RD_REQ -> RD_ACK 2 cycles after grant with RD_DATA=40'h12_3456_789A. Change CMOS_IN afterwards -> RD_DATA unchanged.
4. WR_REQ and RD_REQ both held high across back-to-back transfers -> grant order READ, WRITE, READ, WRITE. No read grant occurs during SETUP, DRIVE or TURN.
5. Drop ENABLE in the 2nd DRIVE cycle -> OEN=1 at the next edge, 2 TURN cycles, IDLE. With ENABLE=0, requests stay pending with no ACK; raising ENABLE lets them be granted.
6. Assert RST_N=0 mid-DRIVE, between edges -> OEN=1 and CMOS_OUT=0 immediately. After release, a clean write sequence as in scenario 2 follows.
